// File: rtl/tp_bd_tx.sv
// tp_bd_tx: clocked two-phase bundled-data transmitter.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data
//   from the producer; data_out/req_out to the async stage, ack_in
//   back from it; status busy, words_sent, timeout_err, proto_err.
module tp_bd_tx #(
  parameter int DATA_WIDTH     = 3,
  parameter int SETUP_CYCLES   = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  req_out,
  input  logic                  ack_in,
  output logic                  busy,
  output logic [7:0]            words_sent,
  output logic                  timeout_err,
  output logic                  proto_err
);

  localparam logic [3:0]  LP_SETUP = 4'(SETUP_CYCLES);
  localparam logic [15:0] LP_TMO   = 16'(TIMEOUT_CYCLES);
  localparam bit          LP_TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic [3:0]              r_scnt;
  logic [15:0]             r_tcnt;
  logic [15:0]             w_tcnt_inc;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_req;
  logic [7:0]              r_words;
  logic                    r_tmo;
  logic                    r_proto;
  logic                    w_ack_s;
  logic                    w_match;
  logic                    w_accept;
  logic                    w_fire;
  logic                    w_done;
  logic                    w_tick;
  logic                    w_tmo_hit;
  logic                    w_proto;

  assign w_ack_s    = r_sync[SYNC_STAGES-1];
  assign w_match    = (w_ack_s == r_req);
  assign w_tcnt_inc = r_tcnt + 16'd1;

  // Count only unanswered WAIT cycles; hold at all-ones.
  assign w_tick = (r_state == S_WAIT) && !w_match
               && (r_tcnt != 16'hFFFF);
  assign w_tmo_hit = LP_TMO_EN && w_tick
                  && (w_tcnt_inc == LP_TMO);

  // An ack edge with no request outstanding is a protocol fault.
  assign w_proto = (r_state != S_WAIT) && !w_match;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fire      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_scnt == LP_SETUP) begin
          w_fire      = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_match) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sync  <= '0;
      r_scnt  <= '0;
      r_tcnt  <= '0;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_words <= '0;
      r_tmo   <= 1'b0;
      r_proto <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], ack_in};
      if (w_accept) begin
        r_data <= in_data;
        r_scnt <= '0;
      end else if (r_state == S_SETUP) begin
        r_scnt <= r_scnt + 4'd1;
      end
      if (w_fire) begin
        r_req  <= ~r_req;
        r_tcnt <= '0;
      end else if (w_tick) begin
        r_tcnt <= w_tcnt_inc;
      end
      if (w_done) r_words <= r_words + 8'd1;
      if (w_tmo_hit) r_tmo <= 1'b1;
      if (w_proto) r_proto <= 1'b1;
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign data_out    = r_data;
  assign req_out     = r_req;
  assign words_sent  = r_words;
  assign timeout_err = r_tmo;
  assign proto_err   = r_proto;

endmodule

// File: tb/tb_tp_bd_tx.sv
// tb_tp_bd_tx: directed bench for tp_bd_tx.
// Drives/samples 1 time unit after each rising edge.
module tb_tp_bd_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_data = 3'd0;
  logic [2:0] data_out;
  logic       req_out;
  logic       ack_in = 1'b0;
  logic       busy;
  logic [7:0] words_sent;
  logic       timeout_err;
  logic       proto_err;

  int   n_chk = 0;
  int   n_fail = 0;
  bit   auto_ack = 1'b0;
  logic req_d = 1'b0;

  always #5 clk = ~clk;

  tp_bd_tx #(
    .DATA_WIDTH    (3),
    .SETUP_CYCLES  (2),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .data_out   (data_out),
    .req_out    (req_out),
    .ack_in     (ack_in),
    .busy       (busy),
    .words_sent (words_sent),
    .timeout_err(timeout_err),
    .proto_err  (proto_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Async stage model: ack follows req one cycle late.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) begin
      ack_in = req_d;
      req_d  = req_out;
    end
  endtask

  task automatic send(input logic [2:0] d);
    chk("send_rdy", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag,
                           input int maxc);
    for (int i = 0; i < maxc && !in_ready; i++)
      tick();
    chk(tag, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ack_in   = 1'b0;
    auto_ack = 1'b0;
    req_d    = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_rst(input string pfx);
    chk({pfx, "_req"}, {31'd0, req_out}, 32'd0);
    chk({pfx, "_data"}, {29'd0, data_out}, 32'd0);
    chk({pfx, "_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    chk({pfx, "_words"}, {24'd0, words_sent}, 32'd0);
    chk({pfx, "_tmo"}, {31'd0, timeout_err}, 32'd0);
    chk({pfx, "_perr"}, {31'd0, proto_err}, 32'd0);
  endtask

  initial begin
    int   w;
    int   toggles;
    logic [2:0] cur;
    logic prev_req;
    logic acc;

    // Power-on reset
    repeat (3) tick();
    rst_n = 1'b1;
    chk_rst("por");

    // Single word, accepted at edge T
    send(3'b101);
    chk("sw_data_T", {29'd0, data_out}, 32'd5);
    chk("sw_rdy_T", {31'd0, in_ready}, 32'd0);
    chk("sw_busy_T", {31'd0, busy}, 32'd1);
    tick();
    tick();
    chk("sw_req_T2", {31'd0, req_out}, 32'd0);
    tick();
    chk("sw_req_T3", {31'd0, req_out}, 32'd1);
    tick();
    ack_in = 1'b1;
    tick();
    tick();
    chk("sw_rdy_T6", {31'd0, in_ready}, 32'd0);
    tick();
    chk("sw_rdy_T7", {31'd0, in_ready}, 32'd1);
    chk("sw_words", {24'd0, words_sent}, 32'd1);
    chk("sw_data_hold", {29'd0, data_out}, 32'd5);

    // Back-to-back words 1..6, in_valid held high
    do_reset();
    chk("b2b_words0", {24'd0, words_sent}, 32'd0);
    req_d    = req_out;
    auto_ack = 1'b1;
    w        = 1;
    cur      = 3'd0;
    toggles  = 0;
    prev_req = req_out;
    in_data  = 3'd1;
    in_valid = 1'b1;
    for (int c = 0; c < 120; c++) begin
      if (words_sent == 8'd6 && in_ready) break;
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        chk("b2b_acc", {29'd0, data_out}, w);
        cur = w[2:0];
        w++;
        if (w > 6) in_valid = 1'b0;
        in_data = w[2:0];
      end else if (busy) begin
        chk("b2b_hold", {29'd0, data_out},
            {29'd0, cur});
      end
      if (req_out != prev_req) toggles++;
      prev_req = req_out;
    end
    auto_ack = 1'b0;
    in_valid = 1'b0;
    chk("b2b_toggles", toggles, 32'd6);
    chk("b2b_words", {24'd0, words_sent}, 32'd6);
    chk("b2b_rdy", {31'd0, in_ready}, 32'd1);
    chk("b2b_perr", {31'd0, proto_err}, 32'd0);

    // Timeout after 8 unanswered WAIT_ACK cycles
    send(3'b010);
    repeat (3) tick();
    chk("to_req", {31'd0, req_out}, 32'd1);
    repeat (7) tick();
    chk("to_pre", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("to_set", {31'd0, timeout_err}, 32'd1);
    repeat (3) tick();
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    chk("to_data", {29'd0, data_out}, 32'd2);
    chk("to_busy", {31'd0, busy}, 32'd1);
    ack_in = 1'b1;
    wait_idle("to_late_done", 10);
    chk("to_words", {24'd0, words_sent}, 32'd7);
    chk("to_keep", {31'd0, timeout_err}, 32'd1);

    // Reset in WAIT_ACK with req_out=1
    send(3'b111);
    repeat (3) tick();
    chk("rm_req0", {31'd0, req_out}, 32'd0);
    ack_in = 1'b0;
    wait_idle("rm_done", 10);
    chk("rm_words8", {24'd0, words_sent}, 32'd8);
    send(3'b110);
    repeat (3) tick();
    chk("rm_req1", {31'd0, req_out}, 32'd1);
    repeat (2) tick();
    chk("rm_busy", {31'd0, busy}, 32'd1);
    do_reset();
    chk_rst("rm");

    // Spurious ack while idle
    ack_in = 1'b1;
    tick();
    tick();
    chk("pe_early", {31'd0, proto_err}, 32'd0);
    tick();
    chk("pe_set", {31'd0, proto_err}, 32'd1);
    chk("pe_req", {31'd0, req_out}, 32'd0);
    chk("pe_data", {29'd0, data_out}, 32'd0);
    chk("pe_rdy", {31'd0, in_ready}, 32'd1);
    repeat (2) tick();
    chk("pe_sticky", {31'd0, proto_err}, 32'd1);
    do_reset();
    chk("pe_clr", {31'd0, proto_err}, 32'd0);

    // Counter wrap over 256 handshakes
    req_d    = req_out;
    auto_ack = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (words_sent == 8'd255) break;
      tick();
      in_data = 3'(c);
    end
    chk("wr_255", {24'd0, words_sent}, 32'd255);
    for (int c = 0; c < 20; c++) begin
      if (words_sent != 8'd255) break;
      tick();
    end
    chk("wr_0", {24'd0, words_sent}, 32'd0);
    in_valid = 1'b0;
    chk("wr_tmo", {31'd0, timeout_err}, 32'd0);
    chk("wr_perr", {31'd0, proto_err}, 32'd0);
    wait_idle("wr_idle", 20);
    auto_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
